// File: rtl/dht11_sensor_emu_pkg.sv
// Shared DHT11 timing defaults, FSM state encoding and parity helper.
// Used by the sensor emulator and shareable with the host controller.
package dht11_sensor_emu_pkg;

  localparam int unsigned CntW = 16;
  localparam int unsigned NumBits = 40;

  localparam int unsigned DefStartMinUs = 18000;
  localparam int unsigned DefWaitUs     = 30;
  localparam int unsigned DefRespUs     = 80;
  localparam int unsigned DefBitLowUs   = 50;
  localparam int unsigned DefZeroUs     = 26;
  localparam int unsigned DefOneUs      = 70;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRespL,
    StRespH,
    StBitL,
    StBitH,
    StEndL
  } dht_state_e;

  // Checksum byte: plain sum of the four data bytes, wrapping mod 256.
  function automatic logic [7:0] dht_parity(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
// Control/data bundle between a bench or SoC and the DHT11 emulator.
// i_corrupt exists only when DHT_EMU_PARITY_CORRUPT_EN is defined.
interface dht11_sensor_emu_if;
  logic       tick_1us;
  logic [7:0] i_humi_int;
  logic [7:0] i_humi_dec;
  logic [7:0] i_temp_int;
  logic [7:0] i_temp_dec;
`ifdef DHT_EMU_PARITY_CORRUPT_EN
  logic       i_corrupt;
`endif
  logic       o_busy;
  logic       o_frame_done;
  logic [5:0] o_bit_cnt;

  modport master (
`ifdef DHT_EMU_PARITY_CORRUPT_EN
    output i_corrupt,
`endif
    output tick_1us,
    output i_humi_int,
    output i_humi_dec,
    output i_temp_int,
    output i_temp_dec,
    input  o_busy,
    input  o_frame_done,
    input  o_bit_cnt
  );

  modport slave (
`ifdef DHT_EMU_PARITY_CORRUPT_EN
    input  i_corrupt,
`endif
    input  tick_1us,
    input  i_humi_int,
    input  i_humi_dec,
    input  i_temp_int,
    input  i_temp_dec,
    output o_busy,
    output o_frame_done,
    output o_bit_cnt
  );

endinterface

// File: rtl/dht11_sensor_emu_sync2.sv
// Two-flop synchronizer for the asynchronous single-wire line.
// Resets to the idle (released, pulled-up) level so reset never looks like a start pulse.
module dht11_sensor_emu_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dht11_sensor_emu.sv
// Synthesizable DHT11 responder: detects the host start pulse and replies with the
// response preamble plus a 40-bit frame. Define DHT_EMU_PARITY_CORRUPT_EN to add i_corrupt.
module dht11_sensor_emu
  import dht11_sensor_emu_pkg::*;
#(
  parameter int unsigned TStartMinUs = DefStartMinUs,
  parameter int unsigned TWaitUs     = DefWaitUs,
  parameter int unsigned TRespUs     = DefRespUs,
  parameter int unsigned TBitLowUs   = DefBitLowUs,
  parameter int unsigned TZeroUs     = DefZeroUs,
  parameter int unsigned TOneUs      = DefOneUs
) (
  input  logic              clk,
  input  logic              rst,
  dht11_sensor_emu_if.slave bus,
  inout  wire               io_dht
);

  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [5:0]      LastBit = 6'(NumBits - 1);

  dht_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic [CntW-1:0] phase_len;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [39:0]     frame_q, frame_d;
  logic            done_q, done_d;
  logic            line_s;
  logic            drive_low;
  logic            phase_done;
  logic [7:0]      parity;

  dht11_sensor_emu_sync2 #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (io_dht),
    .q_o   (line_s)
  );

`ifdef DHT_EMU_PARITY_CORRUPT_EN
  assign parity = dht_parity(bus.i_humi_int, bus.i_humi_dec, bus.i_temp_int, bus.i_temp_dec)
                  ^ {7'd0, bus.i_corrupt};
`else
  assign parity = dht_parity(bus.i_humi_int, bus.i_humi_dec, bus.i_temp_int, bus.i_temp_dec);
`endif

  assign cnt_inc = cnt_q + 1'b1;

  // Length of the current timed phase; frame_q[39] is always the bit being sent.
  always_comb begin
    phase_len = '0;
    unique case (state_q)
      StWait:           phase_len = CntW'(TWaitUs);
      StRespL, StRespH: phase_len = CntW'(TRespUs);
      StBitL, StEndL:   phase_len = CntW'(TBitLowUs);
      StBitH:           phase_len = frame_q[39] ? CntW'(TOneUs) : CntW'(TZeroUs);
      default:          phase_len = '0;
    endcase
  end

  assign phase_done = bus.tick_1us && (cnt_inc == phase_len);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    done_d    = 1'b0;

    if (state_q == StIdle) begin
      if (!line_s) begin
        if (bus.tick_1us && (cnt_q != CntMax)) begin
          cnt_d = cnt_inc;
        end
      end else if (cnt_q >= CntW'(TStartMinUs)) begin
        // Snapshot here so later input changes cannot tear the frame.
        state_d = StWait;
        cnt_d   = '0;
        frame_d = {bus.i_humi_int, bus.i_humi_dec, bus.i_temp_int, bus.i_temp_dec, parity};
      end else begin
        cnt_d = '0;
      end
    end else if (bus.tick_1us) begin
      cnt_d = phase_done ? '0 : cnt_inc;
      if (phase_done) begin
        unique case (state_q)
          StWait:  state_d = StRespL;
          StRespL: state_d = StRespH;
          StRespH: begin
            state_d   = StBitL;
            bit_cnt_d = '0;
          end
          StBitL:  state_d = StBitH;
          StBitH: begin
            frame_d = {frame_q[38:0], 1'b0};
            if (bit_cnt_q == LastBit) begin
              state_d = StEndL;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              state_d   = StBitL;
            end
          end
          StEndL: begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

  // Driven straight from the async-reset state so reset releases the line at once.
  assign drive_low = (state_q == StRespL) || (state_q == StBitL) || (state_q == StEndL);
  assign io_dht    = drive_low ? 1'b0 : 1'bz;

  assign bus.o_busy       = (state_q != StIdle);
  assign bus.o_frame_done = done_q;
  assign bus.o_bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Self-checking bench: a host model pulses the pulled-up line, records the reply as
// run lengths and compares it against a pulse train built from the data bytes.
module tb_dht11_sensor_emu;

  localparam int TStart = 300;   // shortened start threshold to keep runs brief
  localparam int P      = 2;     // clock cycles per microsecond tick
  localparam int Bound  = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic host_low = 1'b0;
  wire  dht_line;

  int checks = 0;
  int errors = 0;

  int got_len[$];
  bit got_lvl[$];
  int exp_len[$];
  bit exp_lvl[$];

  dht11_sensor_emu_if bus ();

  pullup (dht_line);
  assign dht_line = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emu #(
    .TStartMinUs(TStart)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .io_dht(dht_line)
  );

  always #5 clk = ~clk;

  initial begin
    bus.tick_1us = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.tick_1us = 1'b1;
      @(posedge clk);
      #1 bus.tick_1us = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_drive(input int cycles);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] hi, input logic [7:0] hd,
                           input logic [7:0] ti, input logic [7:0] td, input bit corrupt,
                           input bit scramble);
    logic [7:0] exp_b[5];
    logic [7:0] dec_b[5];
    int sum, busy_gap, dones, tail_bad, mis_resp, mis_bits, mis_end, tot_got, tot_exp;
    bit seen_low, finished, err_flag, lvl;

    bus.i_humi_int = hi;
    bus.i_humi_dec = hd;
    bus.i_temp_int = ti;
    bus.i_temp_dec = td;
`ifdef DHT_EMU_PARITY_CORRUPT_EN
    bus.i_corrupt = corrupt;
`endif

    // Reference pulse train straight from the protocol rules.
    sum = (int'(hi) + int'(hd) + int'(ti) + int'(td)) % 256;
    exp_b = '{hi, hd, ti, td, 8'(sum) ^ {7'd0, corrupt}};
    exp_len.delete();
    exp_lvl.delete();
    exp_lvl.push_back(1'b0); exp_len.push_back(80 * P);
    exp_lvl.push_back(1'b1); exp_len.push_back(80 * P);
    for (int j = 0; j < 40; j++) begin
      exp_lvl.push_back(1'b0); exp_len.push_back(50 * P);
      exp_lvl.push_back(1'b1); exp_len.push_back((exp_b[j / 8][7 - (j % 8)] ? 70 : 26) * P);
    end
    exp_lvl.push_back(1'b0); exp_len.push_back(50 * P);

    host_drive($urandom_range(2 * TStart + 8, 2 * TStart + 40));

    got_len.delete();
    got_lvl.delete();
    busy_gap = 0; dones = 0; tail_bad = 0; seen_low = 0; finished = 0;
    for (int c = 0; c < Bound && !finished; c++) begin
      @(negedge clk);
      lvl = (dht_line === 1'b1);
      if (!lvl) seen_low = 1'b1;
      if (bus.o_frame_done === 1'b1) begin
        dones++;
        finished = 1'b1;
      end else if (seen_low && bus.o_busy !== 1'b1) begin
        busy_gap++;
      end
      if (scramble && bus.o_busy === 1'b1) begin
        bus.i_humi_int = 8'($urandom);
        bus.i_humi_dec = 8'($urandom);
        bus.i_temp_int = 8'($urandom);
        bus.i_temp_dec = 8'($urandom);
      end
      if (got_lvl.size() == 0 || got_lvl[got_lvl.size() - 1] != lvl) begin
        got_lvl.push_back(lvl);
        got_len.push_back(1);
      end else begin
        got_len[got_len.size() - 1] = got_len[got_len.size() - 1] + 1;
      end
    end
    chk({tag, " finished"}, finished, 1);

    repeat (40) begin
      @(negedge clk);
      if (bus.o_frame_done === 1'b1) dones++;
      if (bus.o_busy !== 1'b0 || dht_line !== 1'b1) tail_bad++;
    end
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " idle_after"}, tail_bad, 0);
    chk({tag, " busy_gap"}, busy_gap, 0);
    chk({tag, " run_count"}, got_len.size(), 85);

    mis_resp = 0; mis_bits = 0; mis_end = 0; tot_got = 0; tot_exp = 0;
    for (int k = 0; k < 83; k++) begin
      int gl;
      bit gv, bad;
      gl = (k + 1 < got_len.size()) ? got_len[k + 1] : -1;
      gv = (k + 1 < got_lvl.size()) ? got_lvl[k + 1] : 1'b1;
      bad = (gl != exp_len[k]) || (gv != exp_lvl[k]);
      tot_got += gl;
      tot_exp += exp_len[k];
      if (k < 2) mis_resp += int'(bad);
      else if (k < 82) mis_bits += int'(bad);
      else mis_end += int'(bad);
    end
    chk({tag, " response"}, mis_resp, 0);
    chk({tag, " bit_phases"}, mis_bits, 0);
    chk({tag, " end_low"}, mis_end, 0);
    chk({tag, " total_len"}, tot_got, tot_exp);

    for (int b = 0; b < 5; b++) dec_b[b] = 8'h00;
    for (int j = 0; j < 40; j++) begin
      int h;
      h = (4 + 2 * j < got_len.size()) ? got_len[4 + 2 * j] : 0;
      dec_b[j / 8][7 - (j % 8)] = (h > 48 * P);
    end
    for (int b = 0; b < 5; b++) chk($sformatf("%s byte%0d", tag, b), dec_b[b], exp_b[b]);
    err_flag = (dec_b[4] != 8'((int'(dec_b[0]) + int'(dec_b[1]) + int'(dec_b[2])
                                + int'(dec_b[3])) % 256));
    chk({tag, " host_error"}, err_flag, corrupt);
  endtask

  initial begin
    int idle_bad;
    bit found;

    bus.i_humi_int = 8'h00;
    bus.i_humi_dec = 8'h00;
    bus.i_temp_int = 8'h00;
    bus.i_temp_dec = 8'h00;
`ifdef DHT_EMU_PARITY_CORRUPT_EN
    bus.i_corrupt = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", bus.o_busy, 0);
    chk("reset done", bus.o_frame_done, 0);
    chk("reset bit_cnt", bus.o_bit_cnt, 0);
    chk("reset line", dht_line, 1);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Two short pulses whose sum exceeds the threshold: each must be rejected alone.
    host_drive($urandom_range(400, 440));
    repeat (20) @(posedge clk);
    host_drive($urandom_range(400, 440));
    idle_bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b0 || dht_line !== 1'b1) idle_bad++;
    end
    chk("glitch ignored", idle_bad, 0);

    run_frame("f37", 8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b1);
    run_frame("fFF", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    run_frame("f00", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset while bit 12 is in its low preamble.
    bus.i_humi_int = 8'($urandom);
    host_drive(2 * TStart + 20);
    found = 1'b0;
    for (int c = 0; c < Bound && !found; c++) begin
      @(negedge clk);
      if (bus.o_bit_cnt === 6'd12 && dht_line === 1'b0) found = 1'b1;
    end
    chk("rst reached bit12", found, 1);
    rst = 1'b0;
    #1;
    chk("rst line released", dht_line, 1);
    chk("rst busy", bus.o_busy, 0);
    chk("rst done", bus.o_frame_done, 0);
    chk("rst bit_cnt", bus.o_bit_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);

    run_frame("frnd", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);

`ifdef DHT_EMU_PARITY_CORRUPT_EN
    run_frame("fcor", 8'h37, 8'h00, 8'h19, 8'h05, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
